// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel word capture block.
package sipo_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_word_capture_if.sv
// Serial-in / word-out bus of sipo_word_capture; parity_err exists only with PARITY_CHECK_EN.
interface sipo_word_capture_if #(
  parameter int unsigned WIDTH = sipo_pkg::DEF_WIDTH
) ();

  logic             en;
  logic             d;
  logic             sync;
  logic             word_ready;
  logic             overflow_clr;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overflow;
  logic             busy;
`ifdef PARITY_CHECK_EN
  logic             parity_err;

  modport master (
    output en, d, sync, word_ready, overflow_clr,
    input  word_out, word_valid, overflow, busy, parity_err
  );
  modport slave (
    input  en, d, sync, word_ready, overflow_clr,
    output word_out, word_valid, overflow, busy, parity_err
  );
`else
  modport master (
    output en, d, sync, word_ready, overflow_clr,
    input  word_out, word_valid, overflow, busy
  );
  modport slave (
    input  en, d, sync, word_ready, overflow_clr,
    output word_out, word_valid, overflow, busy
  );
`endif

endinterface

// File: rtl/sipo_out_reg.sv
// Valid/ready holding register for assembled words with sticky overflow on dropped words.
// Carries a parity_err bit alongside the word when PARITY_CHECK_EN is defined.
module sipo_out_reg #(
  parameter int unsigned WIDTH = sipo_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_clr,
`ifdef PARITY_CHECK_EN
  input  logic             i_perr,
  output logic             o_perr,
`endif
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overflow
);

  logic             r_valid;
  logic             r_overflow;
  logic [WIDTH-1:0] r_word;
  logic             w_accept;
  logic             w_drop;

  // A held word is replaced only when the consumer takes it on the same edge.
  assign w_accept = i_load && (!r_valid || i_ready);
  assign w_drop   = i_load && r_valid && !i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word  <= i_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready && !i_load) begin
        r_valid <= 1'b0;
      end
      r_overflow <= w_drop || (r_overflow && !i_clr);
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_accept) begin
      r_perr <= i_perr;
    end
  end

  assign o_perr = r_perr;
`endif

  assign o_word     = r_word;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/sipo_word_capture.sv
// Sync-framed serial-to-parallel capture of WIDTH enabled bits into a valid/ready word register.
// Define PARITY_CHECK_EN to take a trailing even-parity bit per word and report parity_err.
module sipo_word_capture
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sipo_word_capture_if.slave  bus
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_word;
  logic             w_done;
`ifdef PARITY_CHECK_EN
  logic             w_perr;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
    if (MSB_FIRST) return {base[WIDTH-2:0], b};
    else           return {b, base[WIDTH-1:1]};
  endfunction

  assign w_first      = shift_in('0, bus.d);
  assign w_shift_next = shift_in(r_shift, bus.d);

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
    w_done    = 1'b0;
`ifdef PARITY_CHECK_EN
    w_perr    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.en && bus.sync) begin
          w_shift_d = w_first;
          w_cnt_d   = CW'(1);
          w_state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
`ifdef PARITY_CHECK_EN
          if (bus.sync) begin
            w_shift_d = w_first;
            w_cnt_d   = CW'(1);
          end else begin
            w_shift_d = w_shift_next;
            w_cnt_d   = r_cnt + CW'(1);
            if (r_cnt == LAST) w_state_d = PARITY;
          end
`else
          // Completion takes priority over a restart marker on the same edge.
          if (r_cnt == LAST) begin
            w_done    = 1'b1;
            w_shift_d = '0;
            w_cnt_d   = '0;
            w_state_d = IDLE;
          end else if (bus.sync) begin
            w_shift_d = w_first;
            w_cnt_d   = CW'(1);
          end else begin
            w_shift_d = w_shift_next;
            w_cnt_d   = r_cnt + CW'(1);
          end
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bus.en) begin
          if (bus.sync) begin
            w_shift_d = w_first;
            w_cnt_d   = CW'(1);
            w_state_d = SHIFT;
          end else begin
            w_done    = 1'b1;
            w_perr    = (^r_shift) ^ bus.d;
            w_shift_d = '0;
            w_cnt_d   = '0;
            w_state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        w_shift_d = '0;
        w_cnt_d   = '0;
        w_state_d = IDLE;
      end
    endcase
  end

`ifdef PARITY_CHECK_EN
  assign w_word = r_shift;
`else
  assign w_word = w_shift_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign bus.busy = (r_state != IDLE);

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_done),
    .i_word     (w_word),
    .i_ready    (bus.word_ready),
    .i_clr      (bus.overflow_clr),
`ifdef PARITY_CHECK_EN
    .i_perr     (w_perr),
    .o_perr     (bus.parity_err),
`endif
    .o_word     (bus.word_out),
    .o_valid    (bus.word_valid),
    .o_overflow (bus.overflow)
  );

endmodule

// File: tb/tb_sipo_word_capture.sv
// Directed bench for sipo_word_capture: an MSB-first DUT and an LSB-first DUT share stimulus.
module tb_sipo_word_capture;

  localparam int unsigned W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sipo_word_capture_if #(.WIDTH(W)) ifa ();
  sipo_word_capture_if #(.WIDTH(W)) ifb ();

  assign ifb.en           = ifa.en;
  assign ifb.d            = ifa.d;
  assign ifb.sync         = ifa.sync;
  assign ifb.word_ready   = ifa.word_ready;
  assign ifb.overflow_clr = ifa.overflow_clr;

  sipo_word_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  sipo_word_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // Sends frame bits [first, last); bit 0 carries sync, bits 0..7 are w MSB-first, bit 8 parity.
  task automatic send_frame(input logic [7:0] w, input int first, input int last,
                            input bit gap, input bit bad_par);
    for (int i = first; i < last; i++) begin
      logic b;
      b = (i < 8) ? w[7-i] : ((^w) ^ bad_par);
      @(negedge clk);
      ifa.en   = 1'b1;
      ifa.d    = b;
      ifa.sync = (i == 0);
      @(posedge clk);
      #1;
      if (gap && i != FRAME_LEN - 1) begin
        @(negedge clk);
        ifa.en   = 1'b0;
        ifa.sync = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ifa.en   = 1'b0;
    ifa.sync = 1'b0;
    ifa.d    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.en = 1'b0; ifa.d = 1'b0; ifa.sync = 1'b0;
    ifa.word_ready = 1'b0; ifa.overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ifa.word_out !== 8'h00) $display("FAIL reset_word: got %h, expected 00", ifa.word_out); else n_pass++;
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b0) $display("FAIL reset_overflow: got %b, expected 0", ifa.overflow); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", ifa.busy); else n_pass++;
`ifdef PARITY_CHECK_EN
    n_checks++; if (ifa.parity_err !== 1'b0) $display("FAIL reset_perr: got %b, expected 0", ifa.parity_err); else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ifa.word_ready = 1'b1;
    send_frame(8'hB2, 0, FRAME_LEN - 1, 1'b0, 1'b0);
    n_checks++; if (ifa.busy !== 1'b1) $display("FAIL basic_busy_mid: got %b, expected 1", ifa.busy); else n_pass++;
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL basic_valid_early: got %b, expected 0", ifa.word_valid); else n_pass++;
    send_frame(8'hB2, FRAME_LEN - 1, FRAME_LEN, 1'b0, 1'b0);
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL basic_valid: got %b, expected 1", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.word_out !== 8'hB2) $display("FAIL basic_word_msb: got %h, expected b2", ifa.word_out); else n_pass++;
    n_checks++; if (ifb.word_out !== 8'h4D) $display("FAIL basic_word_lsb: got %h, expected 4d", ifb.word_out); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL basic_busy_done: got %b, expected 0", ifa.busy); else n_pass++;
`ifdef PARITY_CHECK_EN
    n_checks++; if (ifa.parity_err !== 1'b0) $display("FAIL basic_perr: got %b, expected 0", ifa.parity_err); else n_pass++;
`endif
    idle_cycle();
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL basic_consumed: got %b, expected 0", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.word_out !== 8'hB2) $display("FAIL basic_word_hold: got %h, expected b2", ifa.word_out); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b0) $display("FAIL basic_overflow: got %b, expected 0", ifa.overflow); else n_pass++;
  endtask

  task automatic test_en_stall();
    int c0;
    ifa.word_ready = 1'b1;
    c0 = cyc;
    send_frame(8'hB2, 0, FRAME_LEN - 1, 1'b1, 1'b0);
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL stall_valid_early: got %b, expected 0", ifa.word_valid); else n_pass++;
    send_frame(8'hB2, FRAME_LEN - 1, FRAME_LEN, 1'b1, 1'b0);
    n_checks++; if (cyc - c0 !== 2 * FRAME_LEN - 1) $display("FAIL stall_latency: got %0d, expected %0d", cyc - c0, 2 * FRAME_LEN - 1); else n_pass++;
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL stall_valid: got %b, expected 1", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.word_out !== 8'hB2) $display("FAIL stall_word: got %h, expected b2", ifa.word_out); else n_pass++;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    ifa.word_ready = 1'b0;
    send_frame(8'hB2, 0, FRAME_LEN, 1'b0, 1'b0);
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL b2b_valid_first: got %b, expected 1", ifa.word_valid); else n_pass++;
    // Clear request spans the dropping edge; the overflow event must win.
    ifa.overflow_clr = 1'b1;
    send_frame(8'h0F, 0, FRAME_LEN, 1'b0, 1'b0);
    ifa.overflow_clr = 1'b0;
    n_checks++; if (ifa.word_out !== 8'hB2) $display("FAIL b2b_word_kept: got %h, expected b2", ifa.word_out); else n_pass++;
    n_checks++; if (ifb.word_out !== 8'h4D) $display("FAIL b2b_word_kept_lsb: got %h, expected 4d", ifb.word_out); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b1) $display("FAIL b2b_overflow: got %b, expected 1", ifa.overflow); else n_pass++;
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL b2b_valid_held: got %b, expected 1", ifa.word_valid); else n_pass++;
    ifa.word_ready = 1'b1;
    idle_cycle();
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b, expected 0", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b1) $display("FAIL b2b_overflow_sticky: got %b, expected 1", ifa.overflow); else n_pass++;
    ifa.overflow_clr = 1'b1;
    idle_cycle();
    ifa.overflow_clr = 1'b0;
    n_checks++; if (ifa.overflow !== 1'b0) $display("FAIL b2b_overflow_clr: got %b, expected 0", ifa.overflow); else n_pass++;
  endtask

  task automatic test_resync();
    ifa.word_ready = 1'b1;
    send_frame(8'hC0, 0, 3, 1'b0, 1'b0);
    send_frame(8'hFF, 0, FRAME_LEN - 1, 1'b0, 1'b0);
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL resync_valid_early: got %b, expected 0", ifa.word_valid); else n_pass++;
    send_frame(8'hFF, FRAME_LEN - 1, FRAME_LEN, 1'b0, 1'b0);
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL resync_valid: got %b, expected 1", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.word_out !== 8'hFF) $display("FAIL resync_word: got %h, expected ff", ifa.word_out); else n_pass++;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    ifa.word_ready = 1'b0;
    send_frame(8'hFF, 0, FRAME_LEN, 1'b0, 1'b0);
    send_frame(8'h00, 0, FRAME_LEN, 1'b0, 1'b0);
    send_frame(8'h3C, 0, 5, 1'b0, 1'b0);
    n_checks++; if (ifa.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b, expected 1", ifa.busy); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b1) $display("FAIL rstmid_overflow_before: got %b, expected 1", ifa.overflow); else n_pass++;
    @(negedge clk);
    ifa.en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ifa.word_out !== 8'h00) $display("FAIL rstmid_word: got %h, expected 00", ifa.word_out); else n_pass++;
    n_checks++; if (ifa.word_valid !== 1'b0) $display("FAIL rstmid_valid: got %b, expected 0", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b, expected 0", ifa.overflow); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", ifa.busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    ifa.word_ready = 1'b1;
    send_frame(8'h3C, 0, FRAME_LEN, 1'b0, 1'b0);
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL rstmid_next_valid: got %b, expected 1", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.word_out !== 8'h3C) $display("FAIL rstmid_next_word: got %h, expected 3c", ifa.word_out); else n_pass++;
    n_checks++; if (ifb.word_out !== 8'h3C) $display("FAIL rstmid_next_word_lsb: got %h, expected 3c", ifb.word_out); else n_pass++;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    ifa.word_ready = 1'b1;
    send_frame(8'h3C, 0, FRAME_LEN, 1'b0, 1'b1);
    n_checks++; if (ifa.word_valid !== 1'b1) $display("FAIL parity_valid: got %b, expected 1", ifa.word_valid); else n_pass++;
    n_checks++; if (ifa.word_out !== 8'h3C) $display("FAIL parity_word: got %h, expected 3c", ifa.word_out); else n_pass++;
    n_checks++; if (ifa.parity_err !== 1'b1) $display("FAIL parity_err: got %b, expected 1", ifa.parity_err); else n_pass++;
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_en_stall();
    test_back_to_back();
    test_resync();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
